// File: rtl/cpu_mem_pkg.sv
// cpu_mem_pkg: shared widths and FSM encoding for the CPU memory responder
// Ports: none (package)
package cpu_mem_pkg;
  localparam int IW = 16;
  localparam int DW = 8;
  localparam int AW = 8;
  typedef enum logic [1:0] {IDLE = 2'd0, LOAD = 2'd1, RUN = 2'd2} state_t;
endpackage

// File: rtl/cpu_mem_if.sv
// cpu_mem_if: loader stream, fetch port, data RAM port and status between CPU side and responder
// Ports: none; modport slave = responder view, modport master = CPU/loader view
interface cpu_mem_if;
  import cpu_mem_pkg::*;
  logic          load_valid;
  logic          load_ready;
  logic [IW-1:0] load_data;
  logic          load_last;
  logic [AW-1:0] pc;
  logic          rom_en;
  logic [IW-1:0] ir;
  logic          cs_ram;
  logic          wr_ram;
  logic [AW-1:0] addr_ram;
  logic [DW-1:0] ram_wdata;
  logic [DW-1:0] ram_rdata;
  logic          start;
  logic [AW:0]   load_cnt;
  logic          load_err;
  modport slave (
    input  load_valid, load_data, load_last, pc, rom_en, cs_ram, wr_ram, addr_ram, ram_wdata,
    output load_ready, ir, ram_rdata, start, load_cnt, load_err
  );
  modport master (
    output load_valid, load_data, load_last, pc, rom_en, cs_ram, wr_ram, addr_ram, ram_wdata,
    input  load_ready, ir, ram_rdata, start, load_cnt, load_err
  );
endinterface

// File: rtl/sp_ram.sv
// sp_ram: single-port RAM with registered read data and optional write-first forwarding
// Ports: clk, rst (sync, active low, clears rdata only), we, re, addr, wdata, rdata
module sp_ram #(
  parameter int WIDTH  = 8,
  parameter int DEPTH  = 256,
  parameter bit WR_FWD = 1'b0
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     we,
  input  logic                     re,
  input  logic [$clog2(DEPTH)-1:0] addr,
  input  logic [WIDTH-1:0]         wdata,
  output logic [WIDTH-1:0]         rdata
);
  logic [WIDTH-1:0] mem [DEPTH];
  always_ff @(posedge clk)
    if (we) mem[addr] <= wdata;
  always_ff @(posedge clk)
    if (!rst) rdata <= '0;
    else if (we && WR_FWD) rdata <= wdata;
    else if (re) rdata <= mem[addr];
endmodule

// File: rtl/cpu_mem_responder.sv
// cpu_mem_responder: loads the instruction store over a valid/ready stream, then serves fetches and data RAM
// Ports: clk, rst (sync, active low), bus (cpu_mem_if.slave: loader, fetch, data RAM, start/load_cnt/load_err)
// Config: MEM_WR_FWD_EN makes data RAM writes also update ram_rdata (write-first)
module cpu_mem_responder
  import cpu_mem_pkg::*;
(
  input logic      clk,
  input logic      rst,
  cpu_mem_if.slave bus
);
`ifdef MEM_WR_FWD_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif
  state_t        state;
  logic [AW-1:0] ptr;
  logic          run;
  logic          xfer;
  assign run  = state == RUN;
  assign xfer = bus.load_valid & bus.load_ready;
  // Store is only written in LOAD and only read in RUN, so one address port suffices.
  sp_ram #(.WIDTH(IW), .DEPTH(2**AW), .WR_FWD(1'b0)) u_rom (
    .clk(clk), .rst(rst),
    .we(rst & xfer), .re(rst & run & bus.rom_en),
    .addr(run ? bus.pc : ptr), .wdata(bus.load_data), .rdata(bus.ir)
  );
  sp_ram #(.WIDTH(DW), .DEPTH(2**AW), .WR_FWD(FWD)) u_ram (
    .clk(clk), .rst(rst),
    .we(rst & run & bus.cs_ram & bus.wr_ram), .re(rst & run & bus.cs_ram & ~bus.wr_ram),
    .addr(bus.addr_ram), .wdata(bus.ram_wdata), .rdata(bus.ram_rdata)
  );
  always_ff @(posedge clk)
    if (!rst) begin
      state          <= IDLE;
      ptr            <= '0;
      bus.load_cnt   <= '0;
      bus.load_ready <= 1'b0;
      bus.start      <= 1'b0;
      bus.load_err   <= 1'b0;
    end else if (state == IDLE) begin
      state          <= LOAD;
      ptr            <= '0;
      bus.load_ready <= 1'b1;
    end else if (state == LOAD && xfer) begin
      ptr          <= ptr + 1'b1;
      bus.load_cnt <= bus.load_cnt + 1'b1;
      // Filling the last address ends the load; missing load_last there is flagged.
      if (bus.load_last || &ptr) begin
        state          <= RUN;
        bus.load_ready <= 1'b0;
        bus.start      <= 1'b1;
        bus.load_err   <= ~bus.load_last;
      end
    end
endmodule

// File: tb/tb_cpu_mem_responder.sv
// tb_cpu_mem_responder: randomized self-checking bench against an array-based memory model
module tb_cpu_mem_responder;
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;
  cpu_mem_if bus();
  cpu_mem_responder dut (.clk(clk), .rst(rst), .bus(bus.slave));
  int checks = 0;
  int failures = 0;
  logic [15:0] rom_m [256];
  logic [7:0]  ram_m [256];
  bit          ram_known [256];
  logic [15:0] ir_m;
  logic [7:0]  rd_m;
  bit          rd_valid;
  int          cnt_m;
  bit          run_m;
  bit          err_m;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic quiet;
    bus.load_valid = 0; bus.load_data = '0; bus.load_last = 0;
    bus.pc = '0; bus.rom_en = 0;
    bus.cs_ram = 0; bus.wr_ram = 0; bus.addr_ram = '0; bus.ram_wdata = '0;
  endtask

  task automatic model_reset;
    ir_m = '0; rd_m = '0; rd_valid = 1; cnt_m = 0; run_m = 0; err_m = 0;
  endtask

  task automatic test_reset;
    quiet();
    rst = 0;
    tick(); tick();
    model_reset();
    checks++;
    if ({bus.load_ready, bus.start, bus.load_err, bus.load_cnt, bus.ir, bus.ram_rdata} !== '0) begin
      failures++;
      $display("FAIL reset_outputs got ready=%b start=%b err=%b cnt=%0d ir=%h rdata=%h exp all 0",
               bus.load_ready, bus.start, bus.load_err, bus.load_cnt, bus.ir, bus.ram_rdata);
    end
    rst = 1;
    tick();
    checks++;
    if (bus.load_ready !== 1'b1) begin
      failures++;
      $display("FAIL enter_load got load_ready=%b exp 1", bus.load_ready);
    end
  endtask

  task automatic load_stream(input logic [15:0] words [$], input bit last_on_end, input int gap_at);
    for (int i = 0; i < words.size(); i++) begin
      if (i == gap_at)
        for (int g = 0; g < 3; g++) begin
          bus.load_valid = 0; bus.load_data = 16'($urandom);
          bus.cs_ram = 1; bus.wr_ram = (g != 1); bus.addr_ram = 8'h10; bus.ram_wdata = 8'hC3;
          tick();
          checks++;
          if (bus.load_cnt !== 9'(cnt_m) || bus.ram_rdata !== rd_m) begin
            failures++;
            $display("FAIL load_gap got cnt=%0d rdata=%h exp cnt=%0d rdata=%h", bus.load_cnt, bus.ram_rdata, cnt_m, rd_m);
          end
        end
      bus.cs_ram = 0; bus.wr_ram = 0;
      bus.load_valid = 1; bus.load_data = words[i];
      bus.load_last = last_on_end && (i == words.size() - 1);
      tick();
      if (!run_m) begin
        rom_m[cnt_m] = words[i];
        cnt_m++;
        run_m = bus.load_last || cnt_m == 256;
        err_m = cnt_m == 256 && !bus.load_last;
      end
      checks++;
      if (bus.load_cnt !== 9'(cnt_m)) begin
        failures++;
        $display("FAIL load_cnt word=%0d got=%0d exp=%0d", i, bus.load_cnt, cnt_m);
      end
    end
    bus.load_valid = 0; bus.load_last = 0;
    checks++;
    if ({bus.load_ready, bus.start, bus.load_err} !== {!run_m, run_m, err_m}) begin
      failures++;
      $display("FAIL load_end got ready=%b start=%b err=%b exp ready=%b start=%b err=%b",
               bus.load_ready, bus.start, bus.load_err, !run_m, run_m, err_m);
    end
  endtask

  task automatic test_basic_load;
    logic [15:0] w [$];
    w = '{16'h1234, 16'hA001, 16'h0F0F, 16'hBEEF};
    load_stream(w, 1, -1);
  endtask

  task automatic test_fetch;
    bus.pc = 8'd2; bus.rom_en = 1;
    tick();
    checks++;
    if (bus.ir !== 16'h0F0F) begin
      failures++;
      $display("FAIL fetch_pc2 got=%h exp=0f0f", bus.ir);
    end
    bus.pc = 8'd3; bus.rom_en = 0;
    tick();
    checks++;
    if (bus.ir !== 16'h0F0F) begin
      failures++;
      $display("FAIL fetch_hold got=%h exp=0f0f", bus.ir);
    end
    ir_m = 16'h0F0F;
  endtask

  task automatic test_ram;
    bus.cs_ram = 1; bus.wr_ram = 1; bus.addr_ram = 8'h10; bus.ram_wdata = 8'h5A;
    tick();
    ram_m[8'h10] = 8'h5A; ram_known[8'h10] = 1;
`ifdef MEM_WR_FWD_EN
    rd_m = 8'h5A;
`endif
    checks++;
    if (bus.ram_rdata !== rd_m) begin
      failures++;
      $display("FAIL ram_write_cycle got=%h exp=%h", bus.ram_rdata, rd_m);
    end
    bus.wr_ram = 0;
    tick();
    bus.cs_ram = 0;
    rd_m = 8'h5A;
    checks++;
    if (bus.ram_rdata !== 8'h5A) begin
      failures++;
      $display("FAIL ram_read got=%h exp=5a", bus.ram_rdata);
    end
  endtask

  task automatic test_concurrent;
    for (int i = 0; i < 40; i++) begin
      logic [7:0] a;
      logic [7:0] wd;
      a = 8'($urandom_range(32, 39));
      wd = 8'($urandom);
      bus.pc = 8'($urandom_range(0, cnt_m - 1)); bus.rom_en = 1'($urandom);
      bus.cs_ram = 1'($urandom); bus.wr_ram = 1'($urandom); bus.addr_ram = a; bus.ram_wdata = wd;
      tick();
      if (bus.rom_en) ir_m = rom_m[bus.pc];
      if (bus.cs_ram && bus.wr_ram) begin
        ram_m[a] = wd; ram_known[a] = 1;
`ifdef MEM_WR_FWD_EN
        rd_m = wd; rd_valid = 1;
`endif
      end else if (bus.cs_ram) begin
        rd_m = ram_m[a]; rd_valid = ram_known[a];
      end
      checks++;
      if (bus.ir !== ir_m || (rd_valid && bus.ram_rdata !== rd_m)) begin
        failures++;
        $display("FAIL concurrent iter=%0d got ir=%h rdata=%h exp ir=%h rdata=%h", i, bus.ir, bus.ram_rdata, ir_m, rd_m);
      end
    end
    quiet();
  endtask

  task automatic test_overflow;
    logic [15:0] w [$];
    test_reset();
    for (int i = 0; i < 256; i++) w.push_back(16'($urandom));
    load_stream(w, 0, -1);
    bus.load_valid = 1; bus.load_data = 16'hDEAD;
    tick();
    bus.load_valid = 0;
    checks++;
    if (bus.load_ready !== 1'b0 || bus.load_cnt !== 9'd256 || bus.load_err !== 1'b1) begin
      failures++;
      $display("FAIL overflow_257 got ready=%b cnt=%0d err=%b exp ready=0 cnt=256 err=1", bus.load_ready, bus.load_cnt, bus.load_err);
    end
    bus.pc = 8'd255; bus.rom_en = 1;
    tick();
    bus.rom_en = 0;
    checks++;
    if (bus.ir !== rom_m[255]) begin
      failures++;
      $display("FAIL overflow_last_word got=%h exp=%h", bus.ir, rom_m[255]);
    end
  endtask

  task automatic test_stall;
    logic [15:0] w [$];
    test_reset();
    for (int i = 0; i < 8; i++) w.push_back(16'($urandom));
    load_stream(w, 1, 3);
    bus.cs_ram = 1; bus.wr_ram = 0; bus.addr_ram = 8'h10;
    bus.pc = 8'd3; bus.rom_en = 1;
    tick();
    quiet();
    checks++;
    if (bus.ram_rdata !== ram_m[8'h10] || bus.ir !== rom_m[3]) begin
      failures++;
      $display("FAIL stall_ram_untouched got rdata=%h ir=%h exp rdata=%h ir=%h", bus.ram_rdata, bus.ir, ram_m[8'h10], rom_m[3]);
    end
    rd_m = ram_m[8'h10]; ir_m = rom_m[3];
  endtask

  task automatic test_rerun;
    logic [15:0] w [$];
    logic [15:0] old100;
    old100 = rom_m[100];
    rst = 0;
    tick();
    rst = 1;
    model_reset();
    checks++;
    if ({bus.start, bus.ir, bus.ram_rdata, bus.load_ready} !== '0) begin
      failures++;
      $display("FAIL rerun_reset got start=%b ir=%h rdata=%h ready=%b exp all 0", bus.start, bus.ir, bus.ram_rdata, bus.load_ready);
    end
    tick();
    checks++;
    if (bus.load_ready !== 1'b1 || bus.start !== 1'b0) begin
      failures++;
      $display("FAIL rerun_load got ready=%b start=%b exp ready=1 start=0", bus.load_ready, bus.start);
    end
    w.push_back(16'($urandom));
    load_stream(w, 1, -1);
    bus.pc = 8'd0; bus.rom_en = 1;
    tick();
    checks++;
    if (bus.ir !== rom_m[0]) begin
      failures++;
      $display("FAIL rerun_new_word got=%h exp=%h", bus.ir, rom_m[0]);
    end
    bus.pc = 8'd100;
    tick();
    bus.rom_en = 0;
    checks++;
    if (bus.ir !== old100) begin
      failures++;
      $display("FAIL rerun_old_word got=%h exp=%h", bus.ir, old100);
    end
  endtask

  initial begin
    for (int i = 0; i < 256; i++) ram_known[i] = 0;
    test_reset();
    test_basic_load();
    test_fetch();
    test_ram();
    test_concurrent();
    test_overflow();
    test_stall();
    test_rerun();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
